operand_fetch: RTL

Operand-fetch stage between the RV32IC decoder and the execute stage. Drives the register file's two read ports from decoded source indices and resolves operands with bypass from EX, MEM and WB. Detects RAW hazards and inserts bubbles. Captures operands, immediate, PC and control into a valid/ready pipeline register feeding EX.

---
 rtl/operand_fetch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register-file read, EX/MEM/WB bypass, RAW hazard stall and EX pipeline register.
// Optional build macro OPFETCH_PERF_EN adds the 32-bit perf_stall_cnt output.
module operand_fetch #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic              id_is_load,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [CTRL_W-1:0] id_ctrl,
   output logic [4:0]        rf_read_addr0,
   output logic [4:0]        rf_read_addr1,
   input  logic [XLEN-1:0]   rf_dout0,
   input  logic [XLEN-1:0]   rf_dout1,
   input  logic              ex_fwd_valid,
   input  logic              ex_fwd_pending,
   input  logic [4:0]        ex_fwd_addr,
   input  logic [XLEN-1:0]   ex_fwd_data,
   input  logic              mem_fwd_valid,
   input  logic [4:0]        mem_fwd_addr,
   input  logic [XLEN-1:0]   mem_fwd_data,
   input  logic              wb_we,
   input  logic [4:0]        wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [XLEN-1:0]   ex_rs1_val,
   output logic [XLEN-1:0]   ex_rs2_val,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_pc,
   output logic [4:0]        ex_rd,
   output logic              ex_is_load,
   output logic [CTRL_W-1:0] ex_ctrl
`ifdef OPFETCH_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt
`endif
);

   logic              r_ex_valid;
   logic [XLEN-1:0]   r_ex_rs1_val;
   logic [XLEN-1:0]   r_ex_rs2_val;
   logic [XLEN-1:0]   r_ex_imm;
   logic [XLEN-1:0]   r_ex_pc;
   logic [4:0]        r_ex_rd;
   logic              r_ex_is_load;
   logic [CTRL_W-1:0] r_ex_ctrl;

   logic [XLEN-1:0]   w_rs1_val;
   logic [XLEN-1:0]   w_rs2_val;
   logic              w_haz_rs1;
   logic              w_haz_rs2;
   logic              w_hazard;
   logic              w_adv;
   logic              w_accept;

   // Youngest producer wins; forwards aimed at x0 never match.
   function automatic logic [XLEN-1:0] f_operand(
      input logic [4:0]      idx,
      input logic [XLEN-1:0] rf_val,
      input logic            exv,
      input logic [4:0]      exa,
      input logic [XLEN-1:0] exd,
      input logic            memv,
      input logic [4:0]      mema,
      input logic [XLEN-1:0] memd,
      input logic            wbv,
      input logic [4:0]      wba,
      input logic [XLEN-1:0] wbd
   );
      logic [XLEN-1:0] v;
      v = rf_val;
      if (idx == 5'd0)                       v = '0;
      else if (exv  && exa  == idx)          v = exd;
      else if (memv && mema == idx)          v = memd;
      else if (wbv  && wba  == idx)          v = wbd;
      return v;
   endfunction

   function automatic logic f_hazard(
      input logic       uses,
      input logic [4:0] idx,
      input logic       out_valid,
      input logic [4:0] out_rd,
      input logic       pend,
      input logic [4:0] pend_addr
   );
      return uses && (idx != 5'd0) &&
             ((out_valid && out_rd == idx) || (pend && pend_addr == idx));
   endfunction

   assign rf_read_addr0 = id_rs1;
   assign rf_read_addr1 = id_rs2;

   always_comb begin
      w_rs1_val = f_operand(id_rs1, rf_dout0, ex_fwd_valid, ex_fwd_addr, ex_fwd_data,
                            mem_fwd_valid, mem_fwd_addr, mem_fwd_data, wb_we, wb_addr, wb_data);
      w_rs2_val = f_operand(id_rs2, rf_dout1, ex_fwd_valid, ex_fwd_addr, ex_fwd_data,
                            mem_fwd_valid, mem_fwd_addr, mem_fwd_data, wb_we, wb_addr, wb_data);
   end

   // An instruction sitting in the output register has not produced its result anywhere yet.
   assign w_haz_rs1 = f_hazard(id_uses_rs1, id_rs1, r_ex_valid, r_ex_rd, ex_fwd_pending, ex_fwd_addr);
   assign w_haz_rs2 = f_hazard(id_uses_rs2, id_rs2, r_ex_valid, r_ex_rd, ex_fwd_pending, ex_fwd_addr);
   assign w_hazard  = w_haz_rs1 || w_haz_rs2;
   assign w_adv     = !r_ex_valid || ex_ready;
   assign id_ready  = w_adv && !w_hazard && !flush;
   assign w_accept  = id_valid && id_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_valid   <= 1'b0;
         r_ex_rs1_val <= '0;
         r_ex_rs2_val <= '0;
         r_ex_imm     <= '0;
         r_ex_pc      <= '0;
         r_ex_rd      <= '0;
         r_ex_is_load <= 1'b0;
         r_ex_ctrl    <= '0;
      end else if (flush) begin
         r_ex_valid <= 1'b0;
      end else if (w_accept) begin
         r_ex_valid   <= 1'b1;
         r_ex_rs1_val <= w_rs1_val;
         r_ex_rs2_val <= w_rs2_val;
         r_ex_imm     <= id_imm;
         r_ex_pc      <= id_pc;
         r_ex_rd      <= id_rd;
         r_ex_is_load <= id_is_load;
         r_ex_ctrl    <= id_ctrl;
      end else if (w_adv) begin
         r_ex_valid <= 1'b0;
      end
   end

   assign ex_valid   = r_ex_valid;
   assign ex_rs1_val = r_ex_rs1_val;
   assign ex_rs2_val = r_ex_rs2_val;
   assign ex_imm     = r_ex_imm;
   assign ex_pc      = r_ex_pc;
   assign ex_rd      = r_ex_rd;
   assign ex_is_load = r_ex_is_load;
   assign ex_ctrl    = r_ex_ctrl;

`ifdef OPFETCH_PERF_EN
   logic [31:0] r_perf_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_perf_stall_cnt <= '0;
      else if (id_valid && w_hazard && !flush)
         r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
   end

   assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
